mem_request_arbiter: RTL and testbench
======================================

MEM_REQUEST_ARBITER -- requirements
Module: mem_request_arbiter

Interface
REQ-001 SHALL have parameter N_CHANNELS, default 2, number of requesters (2..8).
REQ-002 SHALL have parameter ADDRESS_BITS, default 16, word address width.
REQ-003 SHALL have parameter BITS, default 16, data width.
REQ-004 SHALL have parameter MODE, default 1, arbitration mode (0 fixed priority, 1 round robin).
REQ-005 SHALL have parameter STARVE_LIMIT, default 4, losses tolerated before promotion in fixed mode (1..15).
REQ-006 SHALL have CLK  input  1  single clock, all state on rising edge.
REQ-007 SHALL have RSTb  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have ch_valid  input  N_CHANNELS  per-channel request.
REQ-009 SHALL have ch_wr  input  N_CHANNELS  per-channel write (1) / read (0).
REQ-010 SHALL have ch_address  input  N_CHANNELS*ADDRESS_BITS  packed addresses, channel i at slice i.
REQ-011 SHALL have ch_data  input  N_CHANNELS*BITS  packed write data.
REQ-012 SHALL have ch_wr_mask  input  N_CHANNELS*2  packed byte write masks.
REQ-013 SHALL have ch_done  output  N_CHANNELS  one-cycle completion pulse.
REQ-014 SHALL have ch_rdata  output  BITS  read data, valid while any ch_done bit high.
REQ-015 SHALL have hold  input  1  inhibits new grants (halt).
REQ-016 SHALL have memory_address  output  ADDRESS_BITS, memory_out  output  BITS, memory_wr  output  1, memory_wr_mask  output  2, memory_valid  output  1, memory_in  input  BITS, memory_ready  input  1: downstream bus.

Function
REQ-017 SHALL implement states IDLE, BUSY, RESP.
REQ-018 SHALL, in IDLE with hold=0 and any ch_valid set, select one winner, register its index, address, data, wr, mask, and enter BUSY next cycle.
REQ-019 SHALL, in IDLE with hold=1 or no ch_valid, remain IDLE with memory_valid=0.
REQ-020 SHALL drive memory_valid=1 and all memory_* fields from registers throughout BUSY, stable until memory_ready.
REQ-021 SHALL, on memory_ready=1 in BUSY, capture memory_in into ch_rdata (reads only; writes leave ch_rdata unchanged) and enter RESP.
REQ-022 SHALL assert ch_done[winner] for exactly the RESP cycle, then return to IDLE.
REQ-023 SHALL give minimum latency of 3 cycles from grant sample to ch_done when memory_ready is high on first BUSY cycle.
REQ-024 SHALL require requesters to hold valid and fields stable until ch_done; a valid deasserted before ch_done SHALL NOT cancel the in-flight access.
REQ-025 SHALL, in MODE 1, search from (last_grant+1) mod N_CHANNELS upward with wrap, updating last_grant on each grant; last_grant resets to N_CHANNELS-1.
REQ-026 SHALL, in MODE 0, grant the lowest-index requesting channel, except as REQ-027.
REQ-027 SHALL, in MODE 0, keep a 4-bit loss counter per channel incremented when it requests in IDLE and loses, cleared on its grant; a channel whose counter reaches STARVE_LIMIT SHALL win, lowest such index first; counters saturate at 15.
REQ-028 SHALL ignore hold once BUSY entered; in-flight access completes.
REQ-029 SHALL ignore ch_valid of non-winning channels outside IDLE.

Reset
REQ-030 SHALL, on RSTb=0, immediately force state IDLE, memory_valid=0, memory_wr=0, memory_wr_mask=0, memory_address=0, memory_out=0, ch_done=0, ch_rdata=0, loss counters 0.
REQ-031 SHALL abandon any in-flight access on reset without a ch_done pulse.

Structure
REQ-032 SHALL take state encoding and MODE constants from shared package mem_arb_pkg.
REQ-033 SHALL place winner selection (mask, rotate, priority encode) in sub-module arb_priority_picker.

Verification
REQ-034 Reset: RSTb low during BUSY -> memory_valid 0 same cycle, no ch_done.
REQ-035 MODE 1, N=3, all channels valid continuously, memory_ready tied 1 -> grant order 0,1,2,0; ch_done every 3 cycles.
REQ-036 MODE 0, N=2, STARVE_LIMIT 2, both valid continuously -> grants 0,0,1,0,0,1.
REQ-037 Read ch1 address 0x1234, memory_ready delayed 5 cycles, memory_in 0xBEEF -> memory_valid high 6 cycles, address stable, ch_done[1] with ch_rdata 0xBEEF.
REQ-038 Write ch0 data 0x00AA mask 2'b01, hold raised during BUSY -> write completes, then no grant while hold=1.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared state encoding, arbitration-mode constants and sizing helpers
// for the memory request arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    localparam int unsigned MODE_FIXED = 0;
    localparam int unsigned MODE_RR    = 1;

    localparam int unsigned MASK_W  = 2;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CNT_MAX = 15;

    // Index width for a channel count, never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_priority_picker.sv
// Winner selection: round-robin rotate-and-encode, or fixed priority with
// starvation override.
module arb_priority_picker
    import mem_arb_pkg::*;
#(
    parameter int unsigned N_CHANNELS = 2,
    parameter int unsigned MODE       = MODE_RR,
    localparam int unsigned IDX_W     = idx_width(N_CHANNELS)
) (
    input  logic [N_CHANNELS-1:0] req,
    input  logic [N_CHANNELS-1:0] starve,
    input  logic [IDX_W-1:0]      last_grant,
    output logic                  grant_valid_c,
    output logic [IDX_W-1:0]      grant_idx_c
);

    logic [2*N_CHANNELS-1:0] doubled;
    logic [N_CHANNELS-1:0]   cand;
    logic [IDX_W-1:0]        start;
    logic [IDX_W-1:0]        enc;
    logic [IDX_W:0]          sum;

    // Rotate so the search origin lands at bit 0, encode lowest set bit,
    // then undo the rotation modulo the channel count.
    always_comb begin
        doubled = {req, req};
        start   = '0;
        cand    = '0;
        enc     = '0;
        sum     = '0;
        if (MODE == MODE_RR) begin
            start = (last_grant >= IDX_W'(N_CHANNELS - 1)) ? '0 : last_grant + IDX_W'(1);
            cand  = N_CHANNELS'(doubled >> start);
        end else begin
            cand = (|starve) ? starve : req;
        end
        for (int i = N_CHANNELS - 1; i >= 0; i--) begin
            if (cand[i]) enc = IDX_W'(i);
        end
        sum = {1'b0, start} + {1'b0, enc};
        if (sum >= (IDX_W + 1)'(N_CHANNELS)) sum = sum - (IDX_W + 1)'(N_CHANNELS);
        grant_idx_c   = IDX_W'(sum);
        grant_valid_c = |req;
    end

endmodule

// File: rtl/mem_request_arbiter.sv
// Multi-channel memory request arbiter: one access in flight at a time,
// IDLE -> BUSY (bus held until ready) -> RESP (one-cycle done pulse).
module mem_request_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned N_CHANNELS   = 2,
    parameter int unsigned ADDRESS_BITS = 16,
    parameter int unsigned BITS         = 16,
    parameter int unsigned MODE         = MODE_RR,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                           CLK,
    input  logic                           RSTb,
    input  logic [N_CHANNELS-1:0]          ch_valid,
    input  logic [N_CHANNELS-1:0]          ch_wr,
    input  logic [N_CHANNELS*ADDRESS_BITS-1:0] ch_address,
    input  logic [N_CHANNELS*BITS-1:0]     ch_data,
    input  logic [N_CHANNELS*MASK_W-1:0]   ch_wr_mask,
    output logic [N_CHANNELS-1:0]          ch_done,
    output logic [BITS-1:0]                ch_rdata,
    input  logic                           hold,
    output logic [ADDRESS_BITS-1:0]        memory_address,
    output logic [BITS-1:0]                memory_out,
    output logic                           memory_wr,
    output logic [MASK_W-1:0]              memory_wr_mask,
    output logic                           memory_valid,
    input  logic [BITS-1:0]                memory_in,
    input  logic                           memory_ready
);

    localparam int unsigned IDX_W = idx_width(N_CHANNELS);

    arb_state_e state_q, state_d;
    logic       grant_c;
    logic       pick_valid_c;
    logic [IDX_W-1:0] pick_idx_c;
    logic [IDX_W-1:0] win_idx_q;
    logic [IDX_W-1:0] last_grant_q;
    logic [N_CHANNELS-1:0][CNT_W-1:0] loss_q;
    logic [N_CHANNELS-1:0] starve_c;

    logic [ADDRESS_BITS-1:0] addr_arr [N_CHANNELS];
    logic [BITS-1:0]         data_arr [N_CHANNELS];
    logic [MASK_W-1:0]       mask_arr [N_CHANNELS];

    // Unpack channel slices and flag channels that have lost too often.
    always_comb begin
        for (int i = 0; i < N_CHANNELS; i++) begin
            addr_arr[i] = ch_address[i*ADDRESS_BITS +: ADDRESS_BITS];
            data_arr[i] = ch_data[i*BITS +: BITS];
            mask_arr[i] = ch_wr_mask[i*MASK_W +: MASK_W];
            starve_c[i] = ch_valid[i] && (loss_q[i] >= CNT_W'(STARVE_LIMIT));
        end
    end

    arb_priority_picker #(
        .N_CHANNELS (N_CHANNELS),
        .MODE       (MODE)
    ) u_picker (
        .req           (ch_valid),
        .starve        (starve_c),
        .last_grant    (last_grant_q),
        .grant_valid_c (pick_valid_c),
        .grant_idx_c   (pick_idx_c)
    );

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        grant_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!hold && pick_valid_c) begin
                    grant_c = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: if (memory_ready) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Grant capture, bus registers, completion pulse and loss bookkeeping.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            win_idx_q      <= '0;
            last_grant_q   <= IDX_W'(N_CHANNELS - 1);
            loss_q         <= '0;
            memory_valid   <= 1'b0;
            memory_wr      <= 1'b0;
            memory_wr_mask <= '0;
            memory_address <= '0;
            memory_out     <= '0;
            ch_done        <= '0;
            ch_rdata       <= '0;
        end else begin
            ch_done <= '0;
            if (grant_c) begin
                win_idx_q      <= pick_idx_c;
                last_grant_q   <= pick_idx_c;
                memory_valid   <= 1'b1;
                memory_address <= addr_arr[pick_idx_c];
                memory_out     <= data_arr[pick_idx_c];
                memory_wr      <= ch_wr[pick_idx_c];
                memory_wr_mask <= mask_arr[pick_idx_c];
                for (int i = 0; i < N_CHANNELS; i++) begin
                    if (IDX_W'(i) == pick_idx_c)
                        loss_q[i] <= '0;
                    else if (ch_valid[i] && (loss_q[i] != CNT_W'(CNT_MAX)))
                        loss_q[i] <= loss_q[i] + CNT_W'(1);
                end
            end
            if ((state_q == ST_BUSY) && memory_ready) begin
                memory_valid       <= 1'b0;
                ch_done[win_idx_q] <= 1'b1;
                if (!memory_wr) ch_rdata <= memory_in;
            end
        end
    end

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed bench: round-robin (N=3) and fixed-priority (N=2, limit 2)
// instances driven step by step with hand-computed expectations.
module tb_mem_request_arbiter;

    logic CLK = 1'b0;
    logic RSTb;

    logic [2:0]  rr_valid, rr_wr, rr_done;
    logic [47:0] rr_addr, rr_data;
    logic [5:0]  rr_mask;
    logic [15:0] rr_rdata, rr_maddr, rr_mout, rr_min;
    logic        rr_hold, rr_mwr, rr_mvalid, rr_mready;
    logic [1:0]  rr_mmask;

    logic [1:0]  fx_valid, fx_wr, fx_done;
    logic [31:0] fx_addr, fx_data;
    logic [3:0]  fx_mask;
    logic [15:0] fx_rdata, fx_maddr, fx_mout, fx_min;
    logic        fx_hold, fx_mwr, fx_mvalid, fx_mready;
    logic [1:0]  fx_mmask;

    int n_tests = 0;
    int n_fail  = 0;
    int rr_order [4] = '{0, 1, 2, 0};
    int fx_order [6] = '{0, 0, 1, 0, 0, 1};

    always #5 CLK = ~CLK;

    mem_request_arbiter #(
        .N_CHANNELS(3), .ADDRESS_BITS(16), .BITS(16), .MODE(1), .STARVE_LIMIT(4)
    ) dut_rr (
        .CLK(CLK), .RSTb(RSTb),
        .ch_valid(rr_valid), .ch_wr(rr_wr), .ch_address(rr_addr),
        .ch_data(rr_data), .ch_wr_mask(rr_mask),
        .ch_done(rr_done), .ch_rdata(rr_rdata), .hold(rr_hold),
        .memory_address(rr_maddr), .memory_out(rr_mout), .memory_wr(rr_mwr),
        .memory_wr_mask(rr_mmask), .memory_valid(rr_mvalid),
        .memory_in(rr_min), .memory_ready(rr_mready)
    );

    mem_request_arbiter #(
        .N_CHANNELS(2), .ADDRESS_BITS(16), .BITS(16), .MODE(0), .STARVE_LIMIT(2)
    ) dut_fx (
        .CLK(CLK), .RSTb(RSTb),
        .ch_valid(fx_valid), .ch_wr(fx_wr), .ch_address(fx_addr),
        .ch_data(fx_data), .ch_wr_mask(fx_mask),
        .ch_done(fx_done), .ch_rdata(fx_rdata), .hold(fx_hold),
        .memory_address(fx_maddr), .memory_out(fx_mout), .memory_wr(fx_mwr),
        .memory_wr_mask(fx_mmask), .memory_valid(fx_mvalid),
        .memory_in(fx_min), .memory_ready(fx_mready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RSTb = 1'b0;
        rr_valid = '0; rr_wr = '0; rr_addr = '0; rr_data = '0; rr_mask = '0;
        rr_hold = 1'b0; rr_min = '0; rr_mready = 1'b0;
        fx_valid = '0; fx_wr = '0; fx_addr = '0; fx_data = '0; fx_mask = '0;
        fx_hold = 1'b0; fx_min = '0; fx_mready = 1'b0;
        #3;
        chk("reset_mvalid", rr_mvalid, 0);
        chk("reset_done", rr_done, 0);
        chk("reset_maddr", rr_maddr, 0);
        chk("reset_rdata", rr_rdata, 0);
        chk("reset_mmask", rr_mmask, 0);
        chk("reset_fx_mvalid", fx_mvalid, 0);
        tick();
        tick();
        RSTb = 1'b1;

        // Round robin, all channels requesting, ready tied high
        rr_addr   = {16'h0102, 16'h0101, 16'h0100};
        rr_min    = 16'h5A5A;
        rr_mready = 1'b1;
        rr_valid  = 3'b111;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_busy_valid", rr_mvalid, 1);
            chk("rr_grant_addr", rr_maddr, 32'h100 + 32'(rr_order[k]));
            chk("rr_busy_nodone", rr_done, 0);
            tick();
            chk("rr_done", rr_done, 32'(1) << rr_order[k]);
            chk("rr_resp_mvalid", rr_mvalid, 0);
            chk("rr_rdata", rr_rdata, 32'h5A5A);
            tick();
            chk("rr_idle_done", rr_done, 0);
        end
        rr_valid = '0;

        // Read on ch1 with ready held off for five BUSY cycles
        rr_valid  = 3'b010;
        rr_addr   = {16'h0000, 16'h1234, 16'h0000};
        rr_mready = 1'b0;
        rr_min    = 16'hBEEF;
        tick();
        for (int c = 0; c < 6; c++) begin
            chk("rd_mvalid_held", rr_mvalid, 1);
            chk("rd_addr_stable", rr_maddr, 32'h1234);
            chk("rd_no_early_done", rr_done, 0);
            if (c == 5) rr_mready = 1'b1;
            tick();
        end
        chk("rd_done_ch1", rr_done, 32'h2);
        chk("rd_rdata", rr_rdata, 32'hBEEF);
        chk("rd_mvalid_drop", rr_mvalid, 0);
        rr_valid  = '0;
        rr_mready = 1'b0;
        tick();
        chk("rd_done_pulse_end", rr_done, 0);

        // Write on ch0, hold raised mid-access
        rr_valid = 3'b001;
        rr_wr    = 3'b001;
        rr_addr  = {16'h0000, 16'h0000, 16'h0040};
        rr_data  = {16'h0000, 16'h0000, 16'h00AA};
        rr_mask  = 6'b000001;
        tick();
        chk("wr_mvalid", rr_mvalid, 1);
        chk("wr_mwr", rr_mwr, 1);
        chk("wr_mout", rr_mout, 32'hAA);
        chk("wr_mmask", rr_mmask, 32'h1);
        chk("wr_maddr", rr_maddr, 32'h40);
        rr_hold = 1'b1;
        tick();
        chk("wr_hold_ignored", rr_mvalid, 1);
        rr_mready = 1'b1;
        tick();
        chk("wr_done_ch0", rr_done, 32'h1);
        chk("wr_rdata_kept", rr_rdata, 32'hBEEF);
        rr_mready = 1'b0;
        tick();
        chk("wr_done_end", rr_done, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("hold_blocks_grant", rr_mvalid, 0);
        end
        rr_hold = 1'b0;
        tick();
        chk("hold_release_grant", rr_mvalid, 1);

        // Asynchronous reset during BUSY
        RSTb = 1'b0;
        #1;
        chk("rst_busy_mvalid", rr_mvalid, 0);
        chk("rst_busy_maddr", rr_maddr, 0);
        tick();
        chk("rst_busy_nodone", rr_done, 0);
        tick();
        RSTb     = 1'b1;
        rr_valid = '0;
        rr_wr    = '0;
        tick();
        chk("rst_after_done", rr_done, 0);
        chk("rst_after_mvalid", rr_mvalid, 0);

        // Fixed priority with starvation promotion
        fx_addr   = {16'h00B1, 16'h00A0};
        fx_mready = 1'b1;
        fx_valid  = 2'b11;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("fx_busy_valid", fx_mvalid, 1);
            chk("fx_grant_addr", fx_maddr, (fx_order[k] == 0) ? 32'hA0 : 32'hB1);
            tick();
            chk("fx_done", fx_done, 32'(1) << fx_order[k]);
            tick();
            chk("fx_idle_done", fx_done, 0);
        end
        fx_valid = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
